// File: rtl/sdram_refresh_sched.sv
// SDRAM auto-refresh scheduler: accumulates refresh debt from the refresh timer, arbitrates
// the command bus with the host and issues PRECHARGE ALL + AUTO REFRESH bursts with tRP/tRFC.
module sdram_refresh_sched #(
    parameter int TRp          = 3,
    parameter int TRfc         = 9,
    parameter int MaxPending   = 8,
    parameter int UrgentThresh = 4
) (
    input  logic                              i_dram_clk,
    input  logic                              i_rst_n,
    input  logic                              i_init_done,
    input  logic                              i_refresh_tick,
    output logic                              o_refresh_en,
    input  logic                              i_host_req,
    output logic                              o_host_gnt,
    input  logic                              i_host_done,
    output logic [1:0]                        o_cmd,
    output logic                              o_busy,
    output logic [$clog2(MaxPending+1)-1:0]   o_pending,
    output logic                              o_overflow
);

    // state    | meaning
    // IDLE     | bus free, deciding between host grant and refresh
    // HOST     | host owns the command bus until it signals done
    // PRECH    | PRECHARGE ALL on the bus
    // WAIT_RP  | NOP while tRP elapses
    // REF      | AUTO REFRESH on the bus, one unit of debt retired
    // WAIT_RFC | NOP while tRFC elapses, then burst again or release

    localparam int PW   = $clog2(MaxPending + 1);
    localparam int TMAX = (TRp > TRfc) ? TRp : TRfc;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_PRE = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;

    localparam logic [PW-1:0] PEND_MAX = PW'(MaxPending);
    localparam logic [PW-1:0] PEND_URG = PW'(UrgentThresh);
    localparam logic [CW-1:0] RP_LOAD  = CW'(TRp - 2);
    localparam logic [CW-1:0] RFC_LOAD = CW'(TRfc - 2);

    typedef enum logic [2:0] {
        IDLE,
        HOST,
        PRECH,
        WAIT_RP,
        REF,
        WAIT_RFC
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   wait_cnt_nxt;
    logic [PW-1:0]   pending;
    logic            urgent;
    logic            has_debt;
    logic            issue;

    assign urgent   = (pending >= PEND_URG);
    assign has_debt = (pending != '0);
    assign issue    = (state == REF);

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (i_init_done) begin
                    if (urgent || (has_debt && !i_host_req)) begin
                        state_nxt = PRECH;
                    end else if (i_host_req) begin
                        state_nxt = HOST;
                    end
                end
            end
            HOST: begin
                if (!i_init_done || i_host_done) begin
                    state_nxt = IDLE;
                end
            end
            PRECH: begin
                state_nxt    = WAIT_RP;
                wait_cnt_nxt = RP_LOAD;
            end
            WAIT_RP: begin
                // losing init here abandons the refresh rather than issuing it
                if (wait_cnt == '0) begin
                    state_nxt = i_init_done ? REF : IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - CW'(1);
                end
            end
            REF: begin
                state_nxt    = WAIT_RFC;
                wait_cnt_nxt = RFC_LOAD;
            end
            WAIT_RFC: begin
                if (wait_cnt == '0) begin
                    if (i_init_done && has_debt && (!i_host_req || urgent)) begin
                        state_nxt = REF;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_dram_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // A tick and an AUTO REFRESH in the same cycle cancel out.
    always_ff @(posedge i_dram_clk) begin
        if (!i_rst_n) begin
            pending    <= '0;
            o_overflow <= 1'b0;
        end else if (!i_init_done) begin
            pending <= '0;
        end else if (i_refresh_tick && !issue) begin
            if (pending == PEND_MAX) begin
                o_overflow <= 1'b1;
            end else begin
                pending <= pending + PW'(1);
            end
        end else if (!i_refresh_tick && issue && has_debt) begin
            pending <= pending - PW'(1);
        end
    end

    // Outputs are flopped from the next state so they line up with the state register.
    always_ff @(posedge i_dram_clk) begin
        if (!i_rst_n) begin
            o_refresh_en <= 1'b0;
            o_host_gnt   <= 1'b0;
            o_cmd        <= CMD_NOP;
            o_busy       <= 1'b0;
        end else begin
            o_refresh_en <= i_init_done;
            o_host_gnt   <= (state_nxt == HOST);
            o_busy       <= (state_nxt == PRECH) || (state_nxt == WAIT_RP) ||
                            (state_nxt == REF)   || (state_nxt == WAIT_RFC);
            if (state_nxt == PRECH) begin
                o_cmd <= CMD_PRE;
            end else if (state_nxt == REF) begin
                o_cmd <= CMD_REF;
            end else begin
                o_cmd <= CMD_NOP;
            end
        end
    end

    assign o_pending = pending;

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Bench for sdram_refresh_sched: directed scenarios then random traffic, every cycle
// compared against a timeline model built from absolute command times.
module tb_sdram_refresh_sched;

    localparam int TRP  = 3;
    localparam int TRFC = 9;
    localparam int MAXP = 8;
    localparam int URG  = 4;
    localparam int PW   = $clog2(MAXP + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init = 1'b0;
    logic          tick = 1'b0;
    logic          req = 1'b0;
    logic          done = 1'b0;
    logic          refresh_en;
    logic          host_gnt;
    logic [1:0]    cmd;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    sdram_refresh_sched #(
        .TRp(TRP), .TRfc(TRFC), .MaxPending(MAXP), .UrgentThresh(URG)
    ) dut (
        .i_dram_clk(clk),
        .i_rst_n(rst_n),
        .i_init_done(init),
        .i_refresh_tick(tick),
        .o_refresh_en(refresh_en),
        .i_host_req(req),
        .o_host_gnt(host_gnt),
        .i_host_done(done),
        .o_cmd(cmd),
        .o_busy(busy),
        .o_pending(pending),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: owner 0=nobody, 1=host, 2=refresh engine; commands placed at absolute cycles.
    int cyc = 0;
    int owner = 0;
    int prech_at = -1000;
    int ar_at = -1000;
    int m_debt = 0;
    int m_ovf = 0;
    int m_en = 0;
    int m_cmd = 0;

    always @(posedge clk) begin
        int  old_debt;
        bit  issued;
        cyc++;
        if (!rst_n) begin
            owner = 0; prech_at = -1000; ar_at = -1000;
            m_debt = 0; m_ovf = 0; m_en = 0;
        end else begin
            old_debt = m_debt;
            issued   = (m_cmd == 2);
            if (owner == 0) begin
                if (init && (old_debt >= URG || (old_debt > 0 && !req))) begin
                    owner = 2; prech_at = cyc; ar_at = cyc + TRP;
                end else if (init && req) begin
                    owner = 1;
                end
            end else if (owner == 1) begin
                if (!init || done) owner = 0;
            end else begin
                if (cyc == ar_at && !init) begin
                    owner = 0;
                end else if (cyc == ar_at + TRFC) begin
                    if (init && old_debt > 0 && (!req || old_debt >= URG)) ar_at = cyc;
                    else owner = 0;
                end
            end
            if (!init) m_debt = 0;
            else if (tick && !issued) begin
                if (m_debt == MAXP) m_ovf = 1;
                else m_debt = m_debt + 1;
            end else if (!tick && issued && m_debt > 0) m_debt = m_debt - 1;
            m_en = init;
        end
        m_cmd = (owner == 2 && cyc == prech_at) ? 1 : ((owner == 2 && cyc == ar_at) ? 2 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("refresh_en", 32'(refresh_en), 32'(m_en));
        chk("host_gnt", 32'(host_gnt), 32'(owner == 1));
        chk("busy", 32'(busy), 32'(owner == 2));
        chk("cmd", 32'(cmd), 32'(m_cmd));
        chk("pending", 32'(pending), 32'(m_debt));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("gnt_busy_excl", 32'(host_gnt & busy), 32'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    // what: 0 grant high, 1 AUTO_REFRESH on bus, 2 refresh idle
    task automatic wait_for(input int what, input int limit, input string tag);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            if ((what == 0 && host_gnt) || (what == 1 && cmd == 2'b10) ||
                (what == 2 && !busy)) seen = 1;
            else cycle();
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cycle(); tick = 1'b0;
    endtask

    initial begin
        int ar_times[$];

        // reset
        repeat (3) cycle();
        chk("reset_cmd", 32'(cmd), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_en", 32'(refresh_en), 32'd0);

        // single refresh, no host
        rst_n = 1'b1; init = 1'b1;
        repeat (3) cycle();
        chk("t1_en", 32'(refresh_en), 32'd1);
        pulse_tick();
        chk("t1_debt", 32'(pending), 32'd1);
        cycle();
        chk("t1_prech", 32'(cmd), 32'd1);
        repeat (TRP) cycle();
        chk("t1_ar", 32'(cmd), 32'd2);
        repeat (TRFC - 1) cycle();
        chk("t1_still_busy", 32'(busy), 32'd1);
        cycle();
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_debt0", 32'(pending), 32'd0);

        // host accrues debt, re-grant below threshold, then urgent burst
        req = 1'b1;
        wait_for(0, 5, "t2_grant");
        repeat (3) begin pulse_tick(); cycle(); end
        chk("t2_debt3", 32'(pending), 32'd3);
        done = 1'b1; cycle(); done = 1'b0;
        chk("t2_release", 32'(host_gnt), 32'd0);
        cycle();
        chk("t2_regrant", 32'(host_gnt), 32'd1);
        pulse_tick();
        chk("t2_debt4", 32'(pending), 32'd4);
        done = 1'b1; req = 1'b0; cycle(); done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (cmd == 2'b10) ar_times.push_back(cyc);
        end
        chk("t2_ar_count", 32'(ar_times.size()), 32'd4);
        for (int i = 1; i < ar_times.size(); i++)
            chk("t2_ar_spacing", 32'(ar_times[i] - ar_times[i-1]), 32'(TRFC));
        req = 1'b1;
        wait_for(0, 5, "t2_grant_resume");

        // saturation and sticky overflow
        repeat (9) pulse_tick();
        chk("t3_sat", 32'(pending), 32'(MAXP));
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_host_kept", 32'(host_gnt), 32'd1);
        done = 1'b1; req = 1'b0; cycle(); done = 1'b0;
        repeat (100) cycle();
        chk("t3_drained", 32'(pending), 32'd0);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // tick coincident with AUTO_REFRESH
        req = 1'b1;
        wait_for(0, 5, "t4_grant");
        pulse_tick(); pulse_tick();
        done = 1'b1; req = 1'b0; cycle(); done = 1'b0;
        wait_for(1, 10, "t4_ar_seen");
        chk("t4_debt_at_ar", 32'(pending), 32'd2);
        pulse_tick();
        chk("t4_debt_kept", 32'(pending), 32'd2);
        repeat (40) cycle();

        // reset in WAIT_RFC, then init low with ticks
        pulse_tick();
        wait_for(1, 10, "t5_ar_seen");
        repeat (2) cycle();
        chk("t5_in_rfc", 32'(busy), 32'd1);
        rst_n = 1'b0; cycle();
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_cmd", 32'(cmd), 32'd0);
        chk("t5_rst_pending", 32'(pending), 32'd0);
        chk("t5_rst_ovf", 32'(overflow), 32'd0);
        chk("t5_rst_en", 32'(refresh_en), 32'd0);
        rst_n = 1'b1; init = 1'b0;
        repeat (4) begin pulse_tick(); cycle(); end
        chk("t5_noinit_debt", 32'(pending), 32'd0);
        chk("t5_noinit_en", 32'(refresh_en), 32'd0);

        // random traffic
        init = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) req = ~req;
            done = host_gnt && ($urandom_range(0, 7) == 0);
            if (i % 700 == 650) init = 1'b0;
            if (i % 700 == 665) init = 1'b1;
            rst_n = (i != 1500);
            cycle();
        end
        tick = 1'b0; done = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
